// File: rtl/mul_seq_ctrl.sv
// Sequential unsigned shift-and-add multiplier controller. Time-shares one external
// WIDTH-bit adder, one pass per cycle, to build a 2*WIDTH-bit product.
module mul_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [WIDTH-1:0]     mplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     add_a,
    output logic [WIDTH-1:0]     add_b,
    output logic                 add_cin,
    input  logic [WIDTH-1:0]     add_sum,
    input  logic                 add_cout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic [WIDTH-1:0]     mc_r_q, mc_r_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            mc_r_q    <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            mc_r_q    <= mc_r_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        mc_r_d    = mc_r_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    hi_d    = '0;
                    lo_d    = mplier;
                    mc_r_d  = mcand;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                add_a = hi_q;
                add_b = lo_q[0] ? mc_r_q : '0;
                // Carry-out becomes the new MSB of hi so no product bit is lost.
                hi_d  = {add_cout, add_sum[WIDTH-1:1]};
                lo_d  = {add_sum[0], lo_q[WIDTH-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    product_d = {add_cout, add_sum, lo_q[WIDTH-1:1]};
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign product = product_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Bench for mul_seq_ctrl: models the external adder and checks against arithmetic
// expectations for the product, the per-iteration adder operands and the timing.
module tb_mul_seq_ctrl;

    localparam int WIDTH = 32;
    localparam int CNT_W = 5;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     mplier;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;
    logic [WIDTH-1:0]     add_a;
    logic [WIDTH-1:0]     add_b;
    logic                 add_cin;
    logic [WIDTH-1:0]     add_sum;
    logic                 add_cout;

    int compared   = 0;
    int mismatched = 0;

    mul_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .mcand   (mcand),
        .mplier  (mplier),
        .busy    (busy),
        .done    (done),
        .product (product),
        .add_a   (add_a),
        .add_b   (add_b),
        .add_cin (add_cin),
        .add_sum (add_sum),
        .add_cout(add_cout)
    );

    // External ripple-carry adder stand-in
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + (WIDTH+1)'(add_cin);

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one operation from IDLE. inj_run>0 pulses a bogus start in that RUN cycle;
    // inj_done pulses a bogus start in the DONE cycle. Ends in the IDLE cycle after DONE.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int inj_run,
                          input bit inj_done, input logic [63:0] prev_prod);
        logic [63:0] exp_prod;
        logic [63:0] pp;
        logic [63:0] mask;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        int          i;
        exp_prod = {32'b0, a} * {32'b0, b};
        mcand  = a;
        mplier = b;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        mcand  = $urandom;
        mplier = $urandom;
        for (int n = 1; n <= WIDTH + 2; n++) begin
            if (n <= WIDTH) begin
                i     = n - 1;
                mask  = (64'd1 << i) - 64'd1;
                pp    = {32'b0, a} * ({32'b0, b} & mask);
                exp_a = 32'(pp >> i);
                exp_b = b[i] ? a : 32'd0;
                chk("busy_run", 64'(busy), 64'd1);
                chk("done_run", 64'(done), 64'd0);
                chk("add_a_run", 64'(add_a), 64'(exp_a));
                chk("add_b_run", 64'(add_b), 64'(exp_b));
                if (n == 1 || n == WIDTH) chk("product_hold_run", product, prev_prod);
            end else if (n == WIDTH + 1) begin
                chk("busy_done", 64'(busy), 64'd0);
                chk("done_pulse", 64'(done), 64'd1);
                chk("product", product, exp_prod);
                chk("add_a_done", 64'(add_a), 64'd0);
                chk("add_b_done", 64'(add_b), 64'd0);
            end else begin
                chk("busy_idle", 64'(busy), 64'd0);
                chk("done_idle", 64'(done), 64'd0);
                chk("product_idle", product, exp_prod);
            end
            chk("add_cin", 64'(add_cin), 64'd0);
            if (n == inj_run) begin
                start = 1'b1; mcand = 32'd100; mplier = 32'd100;
            end else if (inj_done && n == WIDTH + 1) begin
                start = 1'b1; mcand = 32'd100; mplier = 32'd100;
            end else begin
                start = 1'b0;
            end
            if (n < WIDTH + 2) tick();
        end
        start = 1'b0;
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [63:0] last;
        reset  = 1'b1;
        start  = 1'b0;
        mcand  = '0;
        mplier = '0;
        tick();
        tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_product", product, 64'd0);
        chk("rst_add_a", 64'(add_a), 64'd0);
        chk("rst_add_b", 64'(add_b), 64'd0);
        chk("rst_add_cin", 64'(add_cin), 64'd0);
        reset = 1'b0;
        tick();
        chk("idle_busy", 64'(busy), 64'd0);

        run_op(32'd3, 32'd5, 0, 1'b0, 64'd0);

        for (int k = 0; k < 50; k++) begin
            chk("hold_product", product, 64'h0000_0000_0000_000F);
            chk("hold_done", 64'(done), 64'd0);
            chk("hold_adder", {add_a, add_b[30:0], add_cin}, 64'd0);
            tick();
        end

        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, 64'h0000_0000_0000_000F);
        run_op(32'd0, 32'h1234_5678, 0, 1'b0, 64'hFFFF_FFFE_0000_0001);
        run_op(32'h8000_0000, 32'd2, 0, 1'b0, 64'd0);
        run_op(32'd7, 32'd9, 10, 1'b1, 64'h0000_0001_0000_0000);
        tick();
        chk("ignored_start_busy", 64'(busy), 64'd0);
        chk("ignored_start_product", product, 64'd63);
        run_op(32'd100, 32'd100, 0, 1'b0, 64'd63);

        // Reset in the middle of an operation
        mcand  = 32'd6;
        mplier = 32'd7;
        start  = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n < 15; n++) tick();
        chk("pre_reset_busy", 64'(busy), 64'd1);
        #1 reset = 1'b1;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_product", product, 64'd0);
        chk("midrst_adder", {add_a, add_b}, 64'd0);
        tick();
        tick();
        chk("midrst_busy_held", 64'(busy), 64'd0);
        chk("midrst_done_held", 64'(done), 64'd0);
        reset = 1'b0;
        tick();
        chk("post_rst_busy", 64'(busy), 64'd0);
        run_op(32'd6, 32'd7, 0, 1'b0, 64'd0);

        last = 64'd42;
        for (int r = 0; r < 5; r++) begin
            ra = $urandom;
            rb = $urandom;
            if (r == 0) rb = 32'h8000_0001;
            run_op(ra, rb, 0, 1'b0, last);
            last = {32'b0, ra} * {32'b0, rb};
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
